// File: rtl/reg_file_scan_ctrl_pkg.sv
// Shared constants for the register-file debug scan controller:
// FSM state encodings and walk-mode encodings.
`ifndef REG_FILE_SCAN_CTRL_PKG_SV
`define REG_FILE_SCAN_CTRL_PKG_SV

package reg_file_scan_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic MODE_CMP  = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

`endif

// File: rtl/reg_file_scan_ctrl_cmp.sv
// Compare stage of the register scan: checks the read-back word one cycle after
// its address was issued and accumulates the mismatch count and first failing index.
module rf_scan_cmp
    import reg_file_scan_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clear,
    input  logic              capture,
    input  logic [XLEN-1:0]   cap_data,
    input  logic [ADDR_W-1:0] cap_idx,
    input  logic [XLEN-1:0]   rd_data,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              pend_q;
    logic [XLEN-1:0]   exp_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   err_count_q;
    logic              first_err_valid_q;
    logic [ADDR_W-1:0] first_err_addr_q;
    logic              mismatch;

    // rd_data now carries the word addressed in the cycle the beat was captured
    assign mismatch = pend_q && (rd_data != exp_q);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            pend_q            <= 1'b0;
            exp_q             <= '0;
            idx_q             <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
        end else begin
            pend_q <= capture;
            if (capture) begin
                exp_q <= cap_data;
                idx_q <= cap_idx;
            end
            if (clear) begin
                err_count_q       <= '0;
                first_err_valid_q <= 1'b0;
                first_err_addr_q  <= '0;
            end else if (mismatch) begin
                err_count_q <= err_count_q + (ADDR_W + 1)'(1);
                if (!first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_addr_q  <= idx_q;
                end
            end
        end
    end

    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_addr  = first_err_addr_q;

endmodule

// File: rtl/reg_file_scan_ctrl.sv
// Debug sequencer for the core register file: halts the core, then walks every
// register either preloading it from the stream or comparing it against the stream.
module reg_file_scan_ctrl
    import reg_file_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              mode,
    output logic              halt_req,
    input  logic              halt_ack,
    input  logic              exp_valid,
    input  logic [XLEN-1:0]   exp_data,
    output logic              exp_ready,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [XLEN-1:0]   rf_wd,
    input  logic [XLEN-1:0]   rf_rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] idx_q;
    logic              beat;
    logic              last_beat;
    logic              cmp_capture;
    logic              cmp_clear;

    // a dropped halt_ack stalls the walk without losing the pending beat
    assign exp_ready   = (state_q == ST_RUN) && halt_ack;
    assign beat        = exp_valid && exp_ready;
    assign last_beat   = beat && (idx_q == LAST_IDX);
    assign cmp_capture = beat && (mode_q == MODE_CMP);
    assign cmp_clear   = (state_q == ST_IDLE) && start;

    assign halt_req = (state_q == ST_HALT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign rf_addr  = (state_q == ST_RUN) ? idx_q : '0;
    assign rf_we    = beat && (mode_q == MODE_LOAD);
    assign rf_wd    = rf_we ? exp_data : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_HALT;
            ST_HALT:  if (halt_ack) state_d = ST_RUN;
            ST_RUN:   if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CMP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cmp_clear) begin
                mode_q <= mode;
                idx_q  <= '0;
            end else if (beat && !last_beat) begin
                idx_q <= idx_q + ADDR_W'(1);
            end
        end
    end

    rf_scan_cmp #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_cmp (
        .clk             (clk),
        .rstb            (rstb),
        .clear           (cmp_clear),
        .capture         (cmp_capture),
        .cap_data        (exp_data),
        .cap_idx         (idx_q),
        .rd_data         (rf_rd_data),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
    );

endmodule

// File: doc/reg_file_scan_ctrl.md
Name: reg_file_scan_ctrl

Overview:
- Debug sequencer that owns the register-file debug port of philosophy_v_core.
- On command it halts the core and walks all architectural registers in order, in one of two modes:
  - preload: stream 32 words into r00..r31.
  - compare: read r00..r31 and check each against a streamed expected word.
- It reports a mismatch count and the first failing index, so register-state checks run in hardware instead of by hierarchical peeking.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- XLEN, 32, register data width.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rstb  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle command pulse; sampled only in IDLE.
- mode  in  1  0 = compare, 1 = preload; latched with start.
- halt_req  out  1  request to core to freeze fetch/writeback.
- halt_ack  in  1  core is drained and frozen; level signal.
- exp_valid  in  1  stream beat valid (expected value or preload value).
- exp_data  in  XLEN  stream data.
- exp_ready  out  1  stream beat accepted when exp_valid & exp_ready.
- rf_addr  out  ADDR_W  debug port register index.
- rf_we  out  1  debug port write enable.
- rf_wd  out  XLEN  debug port write data.
- rf_rd_data  in  XLEN  debug port read data; returns 1 cycle after rf_addr.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of operation.
- err_count  out  ADDR_W+1  mismatches in last compare (0..NUM_REGS).
- first_err_valid  out  1  at least one mismatch recorded.
- first_err_addr  out  ADDR_W  index of lowest mismatching register.

Behaviour:
- Reset (rstb=0 at a clock edge): state IDLE, idx=0.
  - All outputs 0: halt_req, exp_ready, rf_we, rf_addr, rf_wd, busy, done, err_count, first_err_*.
  - Reset mid-operation aborts immediately and drops halt_req the next cycle.
- FSM states: IDLE, HALT, RUN, DRAIN, FIN.
- IDLE:
  - start=1 latches mode, clears idx, err_count and first_err_* in the same edge, and moves to HALT.
  - start while not IDLE is ignored.
- HALT: halt_req=1; stay until halt_ack=1, then move to RUN.
- RUN:
  - halt_req=1; exp_ready = halt_ack. If halt_ack deasserts, exp_ready=0 and the walk stalls with no rf_we, no idx advance and no beat lost.
  - On an accepted beat:
    - Preload: rf_addr=idx, rf_we=1, rf_wd=exp_data in the same cycle (combinational from the beat). idx 0 is written too; the register file ignores it.
    - Compare: rf_addr=idx, rf_we=0. exp_data and idx are registered into a compare stage. Next cycle, rf_rd_data is compared (full XLEN, !== semantics not needed: 2-state equality).
  - On a mismatch: err_count+1. If first_err_valid=0, set first_err_valid=1 and first_err_addr=compared idx.
  - Back-to-back beats: one register per cycle, with compare overlapping the next read.
  - idx increments per accepted beat. After the beat with idx=NUM_REGS-1, exp_ready=0 and the state moves to DRAIN (no wrap).
- DRAIN: one cycle; completes the final pending compare in compare mode (idle cycle in preload). Then move to FIN.
- FIN: done=1 for exactly one cycle and halt_req=0. Next state IDLE.
  - err_count and first_err_* hold until the next start.
- rf_we is never asserted outside RUN and never in compare mode.
- Latency, zero-stall stream: start→halt_req 1 cycle; halt_ack→first beat accepted 1 cycle (first RUN cycle); last beat→done 2 cycles.

Decomposition:
- Shared header file for debug-controller constants (include-guarded):
  - state encodings (3-bit: IDLE, HALT, RUN, DRAIN, FIN);
  - mode encodings MODE_CMP=0, MODE_LOAD=1.
- One natural sub-module, rf_scan_cmp:
  - holds the compare-stage registers (pending flag, expected word, index);
  - holds err_count, first_err_valid and first_err_addr;
  - is cleared by a clear input pulsed on start.
- The FSM, idx counter and port muxing stay in reg_file_scan_ctrl.

Test Plan:
- Reset: hold rstb=0 for 3 cycles with start=1 → all outputs 0, state IDLE; after release, done stays 0.
- Preload: mode=1, halt_ack 2 cycles after halt_req, stream 32 beats with value = 0x1000_0000+i, no gaps → rf_we pulses 32 consecutive cycles with rf_addr 0..31; done exactly 2 cycles after last beat; halt_req low in the done cycle.
- Compare pass: model RF with r[i]=0x1000_0000+i (r0=0); expected stream matches → err_count=0, first_err_valid=0.
- Compare fail: corrupt expected beats for idx 7 and 20 → err_count=2, first_err_addr=7, first_err_valid=1, holding after done.
- Stalls:
  - random exp_valid gaps, plus halt_ack dropped for 5 cycles at idx 12 → exactly 32 accepted beats;
  - no rf_we while halt_ack=0;
  - results identical to the no-stall run.
- Abort/ignore:
  - start pulsed during RUN → ignored;
  - rstb=0 at idx 15 → next cycle all outputs 0, IDLE; a fresh compare then completes correctly.
